// File: rtl/slot_pkg.sv
// slot_pkg: definitions shared by the slot-machine blocks.
//   - FSM state codes for the coin-out controller
//   - WIN codes reported to the main controller and the display
//   - default prize values, so the LCD logic can show the prize table
//   - helper to size the shared cycle timer
package slot_pkg;

    // Coin-out controller states
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SCORE    = 3'd1;
    localparam logic [2:0] ST_PULSE    = 3'd2;
    localparam logic [2:0] ST_WAIT_ACK = 3'd3;
    localparam logic [2:0] ST_GAP      = 3'd4;
    localparam logic [2:0] ST_FAULTED  = 3'd5;

    // Score codes
    localparam logic [1:0] WIN_NONE   = 2'd0;
    localparam logic [1:0] WIN_PAIR   = 2'd1;
    localparam logic [1:0] WIN_TRIPLE = 2'd2;
    localparam logic [1:0] WIN_SEVEN  = 2'd3;

    // Default prize table and counter width
    localparam int PAY_SEVEN_DEF  = 50;
    localparam int PAY_TRIPLE_DEF = 10;
    localparam int PAY_PAIR_DEF   = 2;
    localparam int CW_DEF         = 7;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/reel_scorer.sv
// reel_scorer: combinational scoring of three stopped reel digits.
// Ports:
//   reel1..reel3 in  4   BCD digits of the stopped reels
//   win          out 2   WIN_NONE / WIN_PAIR / WIN_TRIPLE / WIN_SEVEN
//   pay          out CW  prize in coins for that score
// Only adjacent pairs score; reel1 == reel3 on its own is no win.
module reel_scorer #(
    parameter int CW         = slot_pkg::CW_DEF,
    parameter int PAY_SEVEN  = slot_pkg::PAY_SEVEN_DEF,
    parameter int PAY_TRIPLE = slot_pkg::PAY_TRIPLE_DEF,
    parameter int PAY_PAIR   = slot_pkg::PAY_PAIR_DEF
) (
    input  logic [3:0]    reel1,
    input  logic [3:0]    reel2,
    input  logic [3:0]    reel3,
    output logic [1:0]    win,
    output logic [CW-1:0] pay
);
    import slot_pkg::*;

    logic eq12;
    logic eq23;

    assign eq12 = (reel1 == reel2);
    assign eq23 = (reel2 == reel3);

    always_comb begin
        win = WIN_NONE;
        pay = '0;
        if (eq12 && eq23) begin
            if (reel1 == 4'd7) begin
                win = WIN_SEVEN;
                pay = CW'(PAY_SEVEN);
            end else begin
                win = WIN_TRIPLE;
                pay = CW'(PAY_TRIPLE);
            end
        end else if (eq12 || eq23) begin
            win = WIN_PAIR;
            pay = CW'(PAY_PAIR);
        end
    end

endmodule

// File: rtl/coin_payout.sv
// coin_payout: coin-out controller of the slot machine.
// Scores the stopped reels on EVAL, or pays the whole CREDIT on CASH_OUT,
// and drives the hopper one coin at a time, waiting for HOPPER_ACK on each.
// Ports:
//   CLK, RST     in       clock, synchronous active-high reset
//   EVAL         in  1    pulse: reels stopped, score REEL1..3
//   REEL1..3     in  4    BCD reel digits
//   CASH_OUT     in  1    pulse: pay out CREDIT
//   CREDIT       in  CW   current player credit
//   HOPPER_ACK   in  1    coin-drop sensor (level, already synchronised)
//   HOPPER_EN    out 1    hopper motor drive
//   COIN_DONE    out 1    one pulse per confirmed coin
//   PAY_LEFT     out CW   coins still to pay
//   WIN          out 2    last score code
//   BUSY         out 1    controller not idle
//   FAULT        out 1    sticky hopper-jam flag
module coin_payout #(
    parameter int PULSE_CYC   = 50,
    parameter int GAP_CYC     = 100,
    parameter int TIMEOUT_CYC = 5000,
    parameter int PAY_SEVEN   = slot_pkg::PAY_SEVEN_DEF,
    parameter int PAY_TRIPLE  = slot_pkg::PAY_TRIPLE_DEF,
    parameter int PAY_PAIR    = slot_pkg::PAY_PAIR_DEF,
    parameter int CW          = slot_pkg::CW_DEF
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          EVAL,
    input  logic [3:0]    REEL1,
    input  logic [3:0]    REEL2,
    input  logic [3:0]    REEL3,
    input  logic          CASH_OUT,
    input  logic [CW-1:0] CREDIT,
    input  logic          HOPPER_ACK,
    output logic          HOPPER_EN,
    output logic          COIN_DONE,
    output logic [CW-1:0] PAY_LEFT,
    output logic [1:0]    WIN,
    output logic          BUSY,
    output logic          FAULT
);
    import slot_pkg::*;

    localparam int MAX_CYC = max3(PULSE_CYC, GAP_CYC, TIMEOUT_CYC);
    localparam int TW      = $clog2(MAX_CYC + 1);

    localparam logic [TW-1:0] PULSE_LOAD   = TW'(PULSE_CYC - 1);
    localparam logic [TW-1:0] GAP_LOAD     = TW'(GAP_CYC - 1);
    localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(TIMEOUT_CYC - 1);

    logic [2:0]    state;
    logic [TW-1:0] timer;      // one down-counter shared by PULSE, WAIT_ACK and GAP
    logic [3:0]    reel1_q;
    logic [3:0]    reel2_q;
    logic [3:0]    reel3_q;
    logic          ack_prev;
    logic          ack_mem;    // rising edge seen while the motor was still on
    logic [CW-1:0] pay_left;
    logic [1:0]    win;
    logic          fault;

    logic [1:0]    score_win;
    logic [CW-1:0] score_pay;
    logic          ack_rise;
    logic          coin_take;

    reel_scorer #(
        .CW         (CW),
        .PAY_SEVEN  (PAY_SEVEN),
        .PAY_TRIPLE (PAY_TRIPLE),
        .PAY_PAIR   (PAY_PAIR)
    ) u_scorer (
        .reel1 (reel1_q),
        .reel2 (reel2_q),
        .reel3 (reel3_q),
        .win   (score_win),
        .pay   (score_pay)
    );

    // A held-high sensor counts once: only 0->1 transitions are acks.
    assign ack_rise  = HOPPER_ACK & ~ack_prev;
    assign coin_take = (state == ST_WAIT_ACK) && (ack_mem || ack_rise) && (pay_left != '0);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= ST_IDLE;
            timer    <= '0;
            reel1_q  <= '0;
            reel2_q  <= '0;
            reel3_q  <= '0;
            ack_prev <= 1'b0;
            ack_mem  <= 1'b0;
            pay_left <= '0;
            win      <= WIN_NONE;
            fault    <= 1'b0;
        end else begin
            ack_prev <= HOPPER_ACK;
            case (state)
                ST_IDLE: begin
                    if (EVAL) begin
                        reel1_q <= REEL1;
                        reel2_q <= REEL2;
                        reel3_q <= REEL3;
                        state   <= ST_SCORE;
                    end else if (CASH_OUT) begin
                        pay_left <= CREDIT;
                        if (CREDIT != '0) begin
                            state   <= ST_PULSE;
                            timer   <= PULSE_LOAD;
                            ack_mem <= 1'b0;
                        end
                    end
                end
                ST_SCORE: begin
                    win      <= score_win;
                    pay_left <= score_pay;
                    if (score_pay != '0) begin
                        state   <= ST_PULSE;
                        timer   <= PULSE_LOAD;
                        ack_mem <= 1'b0;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_PULSE: begin
                    if (ack_rise) ack_mem <= 1'b1;
                    if (timer == '0) begin
                        state <= ST_WAIT_ACK;
                        timer <= TIMEOUT_LOAD;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                ST_WAIT_ACK: begin
                    if (coin_take) begin
                        pay_left <= pay_left - 1'b1;
                        ack_mem  <= 1'b0;
                        if (pay_left == CW'(1)) begin
                            state <= ST_IDLE;
                            timer <= '0;
                        end else begin
                            state <= ST_GAP;
                            timer <= GAP_LOAD;
                        end
                    end else if (timer == '0) begin
                        fault <= 1'b1;
                        state <= ST_FAULTED;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                ST_GAP: begin
                    if (timer == '0) begin
                        state   <= ST_PULSE;
                        timer   <= PULSE_LOAD;
                        ack_mem <= 1'b0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                ST_FAULTED: begin
                    state <= ST_FAULTED;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign HOPPER_EN = (state == ST_PULSE);
    assign COIN_DONE = coin_take;
    assign PAY_LEFT  = pay_left;
    assign WIN       = win;
    assign BUSY      = (state != ST_IDLE);
    assign FAULT     = fault;

endmodule

// File: tb/tb_coin_payout.sv
// tb_coin_payout: directed self-checking bench for coin_payout.
// Expected PAY_LEFT values for every coin are queued when a payout is
// started and popped by a monitor on each COIN_DONE pulse.
module tb_coin_payout;

    localparam int PULSE_CYC   = 3;
    localparam int GAP_CYC     = 4;
    localparam int TIMEOUT_CYC = 40;
    localparam int CW          = 7;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          EVAL = 1'b0;
    logic [3:0]    REEL1 = '0;
    logic [3:0]    REEL2 = '0;
    logic [3:0]    REEL3 = '0;
    logic          CASH_OUT = 1'b0;
    logic [CW-1:0] CREDIT = '0;
    logic          HOPPER_ACK = 1'b0;
    logic          HOPPER_EN;
    logic          COIN_DONE;
    logic [CW-1:0] PAY_LEFT;
    logic [1:0]    WIN;
    logic          BUSY;
    logic          FAULT;

    int n_assert = 0;
    int n_fail   = 0;
    int coin_count = 0;
    int en_rises   = 0;
    int high_run   = 0;
    int low_run    = 1000;
    logic en_prev  = 1'b0;
    int exp_q[$];
    int c0;
    int r0;

    coin_payout #(
        .PULSE_CYC   (PULSE_CYC),
        .GAP_CYC     (GAP_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .PAY_SEVEN   (50),
        .PAY_TRIPLE  (10),
        .PAY_PAIR    (2),
        .CW          (CW)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .EVAL       (EVAL),
        .REEL1      (REEL1),
        .REEL2      (REEL2),
        .REEL3      (REEL3),
        .CASH_OUT   (CASH_OUT),
        .CREDIT     (CREDIT),
        .HOPPER_ACK (HOPPER_ACK),
        .HOPPER_EN  (HOPPER_EN),
        .COIN_DONE  (COIN_DONE),
        .PAY_LEFT   (PAY_LEFT),
        .WIN        (WIN),
        .BUSY       (BUSY),
        .FAULT      (FAULT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_en(input logic lvl, input int budget);
        int n;
        n = 0;
        while (HOPPER_EN !== lvl && n < budget) begin
            cycle();
            n++;
        end
        check("wait_hopper_en", {31'd0, HOPPER_EN}, {31'd0, lvl});
    endtask

    task automatic eval(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        REEL1 = a;
        REEL2 = b;
        REEL3 = c;
        EVAL  = 1'b1;
        cycle();
        EVAL  = 1'b0;
    endtask

    task automatic push_payout(input int n);
        for (int k = n; k >= 1; k--) exp_q.push_back(k);
    endtask

    // Acknowledge n coins, each ack rising `delay` cycles after the motor stops.
    task automatic serve(input int n, input int delay, input logic ends_payout);
        for (int i = 0; i < n; i++) begin
            wait_en(1'b1, 200);
            wait_en(1'b0, 200);
            repeat (delay) cycle();
            HOPPER_ACK = 1'b1;
            @(negedge CLK);
            if (ends_payout && i == n - 1) check("busy_at_last_coin", {31'd0, BUSY}, 32'd1);
            cycle();
            if (ends_payout && i == n - 1) begin
                check("busy_after_last_coin", {31'd0, BUSY}, 32'd0);
                check("pay_left_after_last", {25'd0, PAY_LEFT}, 32'd0);
            end
            cycle();
            HOPPER_ACK = 1'b0;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_hopper_en"}, {31'd0, HOPPER_EN}, 32'd0);
        check({tag, "_coin_done"}, {31'd0, COIN_DONE}, 32'd0);
        check({tag, "_pay_left"},  {25'd0, PAY_LEFT},  32'd0);
        check({tag, "_win"},       {30'd0, WIN},       32'd0);
        check({tag, "_busy"},      {31'd0, BUSY},      32'd0);
        check({tag, "_fault"},     {31'd0, FAULT},     32'd0);
    endtask

    // Monitor: coin scoreboard plus pulse-width and inter-coin gap checks.
    always @(negedge CLK) begin
        if (COIN_DONE) begin
            coin_count++;
            n_assert++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL coin_unexpected: observed coin with PAY_LEFT %0d, expected none", PAY_LEFT);
            end
            if (exp_q.size() != 0) check("coin_pay_left", {25'd0, PAY_LEFT}, exp_q.pop_front());
        end
        if (HOPPER_EN && !en_prev) begin
            en_rises++;
            check("gap_min_width", (low_run >= GAP_CYC) ? 32'd1 : 32'd0, 32'd1);
            high_run = 1;
        end else if (HOPPER_EN) begin
            high_run++;
        end
        if (!HOPPER_EN && en_prev) begin
            check("pulse_width", high_run, PULSE_CYC);
            low_run = 1;
        end else if (!HOPPER_EN) begin
            low_run++;
        end
        if (RST) low_run = 1000;
        en_prev = HOPPER_EN;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        RST = 1'b1;
        cycle();
        cycle();
        check_all_zero("reset");
        RST = 1'b0;
        cycle();

        // Three sevens: 50 coins, ack 10 cycles after each motor stop
        push_payout(50);
        c0 = coin_count;
        eval(4'd7, 4'd7, 4'd7);
        check("seven_score_busy", {31'd0, BUSY}, 32'd1);
        check("seven_score_en",   {31'd0, HOPPER_EN}, 32'd0);
        cycle();
        check("seven_latency_en", {31'd0, HOPPER_EN}, 32'd1);
        check("seven_win",        {30'd0, WIN}, 32'd3);
        check("seven_pay_left",   {25'd0, PAY_LEFT}, 32'd50);
        serve(50, 10, 1'b1);
        check("seven_coin_count", coin_count - c0, 32'd50);

        // 3,5,3: no adjacent pair -> nothing paid, busy one cycle
        r0 = en_rises;
        eval(4'd3, 4'd5, 4'd3);
        check("nowin_busy_score", {31'd0, BUSY}, 32'd1);
        cycle();
        check("nowin_busy_after", {31'd0, BUSY}, 32'd0);
        check("nowin_win",        {30'd0, WIN}, 32'd0);
        check("nowin_pay_left",   {25'd0, PAY_LEFT}, 32'd0);
        repeat (4) cycle();
        check("nowin_no_pulses",  en_rises - r0, 32'd0);

        // 3,3,5: pair -> 2 coins
        push_payout(2);
        c0 = coin_count;
        eval(4'd3, 4'd3, 4'd5);
        cycle();
        check("pair_win",      {30'd0, WIN}, 32'd1);
        check("pair_pay_left", {25'd0, PAY_LEFT}, 32'd2);
        serve(2, 3, 1'b1);
        check("pair_coin_count", coin_count - c0, 32'd2);

        // Cash out 4: WIN untouched, 4 pulses
        push_payout(4);
        c0 = coin_count;
        r0 = en_rises;
        CREDIT = 7'd4;
        CASH_OUT = 1'b1;
        cycle();
        CASH_OUT = 1'b0;
        check("cash_pay_left", {25'd0, PAY_LEFT}, 32'd4);
        check("cash_en",       {31'd0, HOPPER_EN}, 32'd1);
        check("cash_win_kept", {30'd0, WIN}, 32'd1);
        serve(4, 2, 1'b1);
        check("cash_coin_count", coin_count - c0, 32'd4);
        check("cash_pulses",     en_rises - r0, 32'd4);

        // Cash out with zero credit: nothing happens
        r0 = en_rises;
        CREDIT = 7'd0;
        CASH_OUT = 1'b1;
        cycle();
        CASH_OUT = 1'b0;
        check("cash0_busy", {31'd0, BUSY}, 32'd0);
        check("cash0_pay",  {25'd0, PAY_LEFT}, 32'd0);
        repeat (5) cycle();
        check("cash0_no_pulses", en_rises - r0, 32'd0);

        // EVAL and CASH_OUT together: scored as EVAL (triple of 1s)
        push_payout(10);
        c0 = coin_count;
        REEL1 = 4'd1; REEL2 = 4'd1; REEL3 = 4'd1;
        CREDIT = 7'd7;
        EVAL = 1'b1;
        CASH_OUT = 1'b1;
        cycle();
        EVAL = 1'b0;
        CASH_OUT = 1'b0;
        cycle();
        check("both_win",      {30'd0, WIN}, 32'd2);
        check("both_pay_left", {25'd0, PAY_LEFT}, 32'd10);
        serve(10, 1, 1'b1);
        check("both_coin_count", coin_count - c0, 32'd10);

        // 2,2,2 with hopper jam on second coin
        exp_q.push_back(10);
        c0 = coin_count;
        eval(4'd2, 4'd2, 4'd2);
        serve(1, 2, 1'b0);
        wait_en(1'b1, 200);
        wait_en(1'b0, 200);
        repeat (TIMEOUT_CYC - 1) cycle();
        check("jam_fault_before", {31'd0, FAULT}, 32'd0);
        cycle();
        check("jam_fault",     {31'd0, FAULT}, 32'd1);
        check("jam_pay_left",  {25'd0, PAY_LEFT}, 32'd9);
        check("jam_busy",      {31'd0, BUSY}, 32'd1);
        check("jam_coins",     coin_count - c0, 32'd1);
        eval(4'd7, 4'd7, 4'd7);
        repeat (5) cycle();
        check("jam_eval_ignored_pay", {25'd0, PAY_LEFT}, 32'd9);
        check("jam_eval_ignored_win", {30'd0, WIN}, 32'd2);
        check("jam_en_low",           {31'd0, HOPPER_EN}, 32'd0);
        RST = 1'b1;
        cycle();
        check_all_zero("jam_reset");
        RST = 1'b0;
        cycle();

        // Ack held high across coin slots counts once
        exp_q.push_back(10);
        c0 = coin_count;
        eval(4'd5, 4'd5, 4'd5);
        wait_en(1'b1, 200);
        wait_en(1'b0, 200);
        HOPPER_ACK = 1'b1;
        repeat (3 * (PULSE_CYC + GAP_CYC) + TIMEOUT_CYC + 10) cycle();
        check("held_ack_coins", coin_count - c0, 32'd1);
        check("held_ack_pay",   {25'd0, PAY_LEFT}, 32'd9);
        check("held_ack_fault", {31'd0, FAULT}, 32'd1);
        HOPPER_ACK = 1'b0;
        RST = 1'b1;
        cycle();
        RST = 1'b0;
        cycle();

        // Reset mid-payout with 6 coins left
        push_payout(8);
        c0 = coin_count;
        CREDIT = 7'd8;
        CASH_OUT = 1'b1;
        cycle();
        CASH_OUT = 1'b0;
        serve(2, 2, 1'b0);
        wait_en(1'b1, 200);
        wait_en(1'b0, 200);
        check("midrst_pay_left", {25'd0, PAY_LEFT}, 32'd6);
        RST = 1'b1;
        cycle();
        check_all_zero("midrst");
        RST = 1'b0;
        check("midrst_abandoned", exp_q.size(), 32'd6);
        exp_q.delete();
        repeat (3) cycle();
        check("midrst_no_coin", coin_count - c0, 32'd2);

        // Normal EVAL after reset
        push_payout(2);
        c0 = coin_count;
        eval(4'd3, 4'd3, 4'd5);
        cycle();
        check("post_rst_win", {30'd0, WIN}, 32'd1);
        serve(2, 3, 1'b1);
        check("post_rst_coins", coin_count - c0, 32'd2);
        check("queue_drained",  exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
